div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand/result width.
REQ-002 SHALL have ports:
  clk  in  1  rising-edge clock, the only clock.
  rst_n  in  1  asynchronous, active-low reset.
  req_valid  in  1  execute stage holds a divide op; held stable while stall=1.
  req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
  req_a  in  DATA_WIDTH  dividend.
  req_b  in  DATA_WIDTH  divisor.
  req_rd  in  5  destination register tag.
  flush  in  1  kill any in-flight op.
  stall  out  1  freeze the pipeline.
  resp_valid  out  1  one-cycle result strobe.
  resp_data  out  DATA_WIDTH  quotient or remainder per req_op.
  resp_rd  out  5  tag of the result.
  div_dividend, div_divisor  out  DATA_WIDTH  operands to the iterative divider.
  div_is_unsigned  out  1  1 for DIVU/REMU.
  div_trigger  out  1  divider start level.
  div_quotient, div_remainder  in  DATA_WIDTH  divider results.
  div_finished  in  1  divider done level; cleared by the divider only after div_trigger falls.

Function
REQ-003 SHALL implement states IDLE, RUN, DRAIN, RESP.
REQ-004 SHALL, in IDLE with req_valid=1 and flush=0, register req_op, req_a, req_b and req_rd.
REQ-005 SHALL, on an IDLE accept with req_b=0, skip the divider and go to RESP with quotient=all-ones and remainder=req_a, for both signed and unsigned ops.
REQ-006 SHALL, on any other IDLE accept, go to RUN.
REQ-007 SHALL hold div_trigger=1 throughout RUN, with div_dividend/div_divisor/div_is_unsigned driven from the registered operands and stable.
REQ-008 SHALL, in RUN when div_finished=1, capture div_quotient and div_remainder, drive div_trigger=0 from the next cycle, and go to DRAIN.
REQ-009 SHALL stay in DRAIN while div_finished=1, then go to RESP, or to IDLE if the op was killed.
REQ-010 SHALL, in RESP, drive resp_valid=1 for exactly one cycle with resp_data = quotient (req_op[1]=0) or remainder (req_op[1]=1) and resp_rd = registered tag, then go to IDLE.
REQ-011 SHALL drive stall = req_valid AND NOT resp_valid (combinational), so the pipeline advances exactly on the RESP cycle.
REQ-012 SHALL, on flush=1 in RUN or DRAIN, set a kill flag and still complete the trigger/finished handshake, since the divider cannot be aborted.
REQ-013 SHALL force resp_valid=0 when flush=1 during RESP, or when the kill flag is set.
REQ-014 SHALL clear the kill flag on entry to IDLE.
REQ-015 SHALL never assert div_trigger outside RUN, and never re-enter RUN while div_finished=1.
REQ-016 SHALL leave DIV MIN/-1 to the divider result: quotient 0x80000000, remainder 0.
REQ-017 SHALL have a latency for non-bypassed ops of resp_valid two cycles after the last div_finished=1 cycle (DRAIN exit plus RESP).

Reset
REQ-018 SHALL, while rst_n=0, asynchronously force state=IDLE, kill=0, div_trigger=0, resp_valid=0, and resp_data, resp_rd, div_dividend, div_divisor, div_is_unsigned to 0.
REQ-019 SHALL, on reset mid-RUN, drop div_trigger immediately, with the divider returned to idle by the shared reset.

Configuration
REQ-020 SHALL, when DIV_SEQUENCER_RESULT_CACHE_EN is defined, keep the last completed, non-killed operands, signedness, quotient and remainder with a valid bit.
REQ-021 SHALL, with the cache enabled, treat an IDLE accept matching a valid cache entry (req_a, req_b, req_op[0]) as a hit: go directly to RESP with the cached result, without triggering the divider.
REQ-022 SHALL clear the cache valid bit on reset.
REQ-023 SHALL, without DIV_SEQUENCER_RESULT_CACHE_EN, omit the cache logic so every nonzero-divisor op goes through RUN.

Verification
REQ-024 DIVU 100/7, rd=5 -> one trigger pulse; resp_valid=1, resp_data=14, resp_rd=5; stall falls on the resp cycle.
REQ-025 REM -7/2 -> resp_data=0xFFFFFFFF (-1); DIV -7/2 -> 0xFFFFFFFD (-3).
REQ-026 DIVU 5/0 and DIV 5/0 -> no div_trigger; resp_data=0xFFFFFFFF two cycles after accept; REMU 5/0 -> 5.
REQ-027 flush mid-RUN -> no resp_valid; div_trigger drops only after div_finished; the next request is accepted after DRAIN and is correct.
REQ-028 With the cache enabled: DIV 1000/3 then REM 1000/3 -> second op gives 1 with no trigger, resp two cycles after accept; with the cache disabled -> full divider latency.
REQ-029 rst_n low mid-RUN -> all outputs 0 asynchronously; after release, DIVU 9/3 -> 3.

Source files
------------

// File: rtl/div_sequencer_if.sv
// -----------------------------------------------------------------------------
// div_sequencer_if
// Execute-stage <-> divide sequencer handshake bundle.
//
//   req_valid  execute stage holds a divide op (held stable while stall=1)
//   req_op     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_a      dividend
//   req_b      divisor
//   req_rd     destination register tag
//   flush      kill any in-flight op
//   stall      freeze the pipeline
//   resp_valid one-cycle result strobe
//   resp_data  quotient or remainder, selected by req_op[1]
//   resp_rd    tag of the result
//
// Modports: master = pipeline side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface div_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic [1:0]            req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic [4:0]            req_rd;
    logic                  flush;
    logic                  stall;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [4:0]            resp_rd;

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, flush,
        input  stall, resp_valid, resp_data, resp_rd
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, flush,
        output stall, resp_valid, resp_data, resp_rd
    );
endinterface

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Sequences DIV/DIVU/REM/REMU ops from the execute stage onto an external
// iterative divider using a level trigger / level finished handshake.
// Divide-by-zero is answered locally (quotient all-ones, remainder = dividend).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       pipeline request/response handshake (div_sequencer_if)
//   div_dividend      registered dividend to the divider
//   div_divisor       registered divisor to the divider
//   div_is_unsigned   1 for DIVU/REMU
//   div_trigger       divider start level, high only in RUN
//   div_quotient      divider quotient result
//   div_remainder     divider remainder result
//   div_finished      divider done level, drops only after div_trigger falls
//
// Optional feature: define DIV_SEQUENCER_RESULT_CACHE_EN to keep a one-entry
// cache of the last completed divider result; a matching request (same
// operands and signedness) is answered without running the divider.
// -----------------------------------------------------------------------------
module div_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    div_sequencer_if.slave        bus,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    output logic                  div_is_unsigned,
    output logic                  div_trigger,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remainder,
    input  logic                  div_finished
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        RESP
    } state_t;

    state_t                state;
    logic                  kill_q;
    logic                  rem_sel_q;   // req_op[1]: return remainder
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] quot_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [4:0]            resp_rd_q;

    // Accept only when the divider is back to idle, so RUN is never
    // re-entered while div_finished is still high from a previous op.
    logic accept;
    logic b_zero;
    logic drain_done;
    logic drain_keep;

    assign accept     = (state == IDLE) && bus.req_valid && !bus.flush && !div_finished;
    assign b_zero     = (bus.req_b == '0);
    assign drain_done = (state == DRAIN) && !div_finished;
    assign drain_keep = drain_done && !kill_q && !bus.flush;

    // A result already flushed (or killed) must never reach the pipeline.
    assign bus.resp_valid = resp_valid_q && !bus.flush && !kill_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.stall      = bus.req_valid && !bus.resp_valid;

`ifdef DIV_SEQUENCER_RESULT_CACHE_EN
    logic                  cache_valid;
    logic                  cache_unsigned;
    logic [DATA_WIDTH-1:0] cache_a;
    logic [DATA_WIDTH-1:0] cache_b;
    logic [DATA_WIDTH-1:0] cache_quot;
    logic [DATA_WIDTH-1:0] cache_rem;
    logic                  cache_hit;

    assign cache_hit = cache_valid
                    && (bus.req_a == cache_a)
                    && (bus.req_b == cache_b)
                    && (bus.req_op[0] == cache_unsigned);

    // Captured when a non-killed divider op leaves DRAIN; the operand
    // registers still hold that op's values at this point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid    <= 1'b0;
            cache_unsigned <= 1'b0;
            cache_a        <= '0;
            cache_b        <= '0;
            cache_quot     <= '0;
            cache_rem      <= '0;
        end else if (drain_keep) begin
            cache_valid    <= 1'b1;
            cache_unsigned <= div_is_unsigned;
            cache_a        <= div_dividend;
            cache_b        <= div_divisor;
            cache_quot     <= quot_q;
            cache_rem      <= rem_q;
        end
    end
`else
    logic                  cache_hit;
    logic [DATA_WIDTH-1:0] cache_quot;
    logic [DATA_WIDTH-1:0] cache_rem;

    assign cache_hit  = 1'b0;
    assign cache_quot = '0;
    assign cache_rem  = '0;
`endif

    // NOTE: every register, including the operand/result holding registers,
    // is reset so the divider sees clean zeros and outputs are defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            kill_q          <= 1'b0;
            rem_sel_q       <= 1'b0;
            rd_q            <= '0;
            quot_q          <= '0;
            rem_q           <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_rd_q       <= '0;
            div_dividend    <= '0;
            div_divisor     <= '0;
            div_is_unsigned <= 1'b0;
            div_trigger     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; later assignments in
            // this block override the default below within the same cycle.
            resp_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (accept) begin
                        rem_sel_q       <= bus.req_op[1];
                        rd_q            <= bus.req_rd;
                        div_dividend    <= bus.req_a;
                        div_divisor     <= bus.req_b;
                        div_is_unsigned <= bus.req_op[0];
                        if (b_zero) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rd_q    <= bus.req_rd;
                            resp_data_q  <= bus.req_op[1] ? bus.req_a : '1;
                        end else if (cache_hit) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rd_q    <= bus.req_rd;
                            resp_data_q  <= bus.req_op[1] ? cache_rem : cache_quot;
                        end else begin
                            state       <= RUN;
                            div_trigger <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The divider cannot be aborted: a flush only marks the op.
                    if (bus.flush) kill_q <= 1'b1;
                    if (div_finished) begin
                        quot_q      <= div_quotient;
                        rem_q       <= div_remainder;
                        div_trigger <= 1'b0;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.flush) kill_q <= 1'b1;
                    if (drain_done) begin
                        if (kill_q || bus.flush) begin
                            state  <= IDLE;
                            kill_q <= 1'b0;
                        end else begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rd_q    <= rd_q;
                            resp_data_q  <= rem_sel_q ? rem_q : quot_q;
                        end
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    kill_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
// Directed bench for div_sequencer with a behavioural iterative divider that
// raises div_finished DIV_LAT trigger cycles after start and drops it one cycle
// after div_trigger falls.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

    localparam int DW       = 32;
    localparam int DIV_LAT  = 4;
    localparam int FULL_LAT = DIV_LAT + 5;  // drive-to-resp sample count via divider
    localparam int BYP_LAT  = 2;            // drive-to-resp sample count, no divider
    localparam int MAX_WAIT = 60;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic          div_is_unsigned;
    logic          div_trigger;
    logic [DW-1:0] div_quotient;
    logic [DW-1:0] div_remainder;
    logic          div_finished;

    div_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    div_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus.slave),
        .div_dividend    (div_dividend),
        .div_divisor     (div_divisor),
        .div_is_unsigned (div_is_unsigned),
        .div_trigger     (div_trigger),
        .div_quotient    (div_quotient),
        .div_remainder   (div_remainder),
        .div_finished    (div_finished)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural divider ----------------
    int cnt;

    function automatic logic [2*DW-1:0] divide(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic uns);
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        if (uns) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {q, r};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_finished  <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
            cnt           <= 0;
        end else if (div_finished) begin
            if (!div_trigger) begin
                div_finished <= 1'b0;
                cnt          <= 0;
            end
        end else if (div_trigger) begin
            if (cnt == DIV_LAT - 1) begin
                div_finished                  <= 1'b1;
                {div_quotient, div_remainder} <= divide(div_dividend, div_divisor, div_is_unsigned);
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    // ---------------- event counters ----------------
    int   trig_count = 0;
    int   resp_count = 0;
    logic trig_prev  = 1'b0;

    always @(posedge clk) begin
        if (div_trigger && !trig_prev) trig_count <= trig_count + 1;
        trig_prev <= div_trigger;
    end

    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) resp_count <= resp_count + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issue one op and wait for its response. lat counts negedge samples from
    // the drive point (0 on timeout).
    task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [4:0] rd, output int lat, output logic [DW-1:0] data,
                          output logic [4:0] rdo, output int trigs, output logic stall_first,
                          output logic stall_resp, output logic uns_seen);
        int base;
        @(posedge clk);
        #1;
        base          = trig_count;
        lat           = 0;
        data          = 'x;
        rdo           = 'x;
        stall_first   = 1'bx;
        stall_resp    = 1'bx;
        uns_seen      = 1'bx;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
        for (int n = 1; n <= MAX_WAIT; n++) begin
            @(negedge clk);
            if (n == 1) stall_first = bus.stall;
            if (n == 2) uns_seen = div_is_unsigned;
            if (bus.resp_valid === 1'b1) begin
                lat        = n;
                data       = bus.resp_data;
                rdo        = bus.resp_rd;
                stall_resp = bus.stall;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        trigs = trig_count - base;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trigger"},  div_trigger, 0);
        check({tag, "_respv"},    bus.resp_valid, 0);
        check({tag, "_respdata"}, bus.resp_data, 0);
        check({tag, "_resprd"},   bus.resp_rd, 0);
        check({tag, "_dividend"}, div_dividend, 0);
        check({tag, "_divisor"},  div_divisor, 0);
        check({tag, "_unsigned"}, div_is_unsigned, 0);
        check({tag, "_stall"},    bus.stall, 0);
    endtask

    initial begin
        int            lat;
        int            trigs;
        int            base_resp;
        logic [DW-1:0] data;
        logic [4:0]    rdo;
        logic          st_first;
        logic          st_resp;
        logic          uns;
        logic          found;

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_rd    = '0;
        bus.flush     = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // ---- DIVU 100/7, rd 5 ----
        run_op(2'b01, 32'd100, 32'd7, 5'd5, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("divu_data", data, 14);
        check("divu_rd", rdo, 5);
        check("divu_trigs", trigs, 1);
        check("divu_lat", lat, FULL_LAT);
        check("divu_stall_before", st_first, 1);
        check("divu_stall_resp", st_resp, 0);
        check("divu_unsigned", uns, 1);
        @(negedge clk);
        check("divu_resp_one_cycle", bus.resp_valid, 0);

        // ---- signed remainder / quotient of negative dividend ----
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("rem_neg_data", data, 32'hFFFF_FFFF);
        check("rem_neg_unsigned", uns, 0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd2, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("div_neg_data", data, 32'hFFFF_FFFD);
        check("div_neg_rd", rdo, 2);

        // ---- divide by zero bypass ----
        run_op(2'b01, 32'd5, 32'd0, 5'd6, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("divu0_data", data, 32'hFFFF_FFFF);
        check("divu0_trigs", trigs, 0);
        check("divu0_lat", lat, BYP_LAT);
        run_op(2'b00, 32'd5, 32'd0, 5'd7, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("div0_data", data, 32'hFFFF_FFFF);
        check("div0_trigs", trigs, 0);
        check("div0_lat", lat, BYP_LAT);
        run_op(2'b11, 32'd5, 32'd0, 5'd8, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("remu0_data", data, 5);
        check("remu0_rd", rdo, 8);

        // ---- MIN / -1 ----
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("divmin_data", data, 32'h8000_0000);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("remmin_data", data, 0);

        // ---- flush during RESP of a bypassed op ----
        @(posedge clk);
        #1;
        base_resp     = resp_count;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd0;
        bus.req_rd    = 5'd4;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_resp_valid", bus.resp_valid, 0);
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("flush_resp_count", resp_count - base_resp, 0);

        // ---- result cache: DIV then REM of the same operands ----
        run_op(2'b00, 32'd1000, 32'd3, 5'd10, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("cache_div_data", data, 333);
        check("cache_div_trigs", trigs, 1);
        run_op(2'b10, 32'd1000, 32'd3, 5'd11, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("cache_rem_data", data, 1);
        check("cache_rem_rd", rdo, 11);
`ifdef DIV_SEQUENCER_RESULT_CACHE_EN
        check("cache_rem_trigs", trigs, 0);
        check("cache_rem_lat", lat, BYP_LAT);
`else
        check("cache_rem_trigs", trigs, 1);
        check("cache_rem_lat", lat, FULL_LAT);
`endif

        // ---- flush mid-RUN ----
        @(posedge clk);
        #1;
        base_resp     = resp_count;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_a     = 32'd50;
        bus.req_b     = 32'd5;
        bus.req_rd    = 5'd3;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("flush_run_trigger_held", div_trigger, 1);
        found = 1'b0;
        for (int n = 0; n < MAX_WAIT; n++) begin
            if (!div_trigger) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("flush_run_trigger_fell", found, 1);
        check("flush_run_finished_at_fall", div_finished, 1);
        run_op(2'b01, 32'd81, 32'd9, 5'd12, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("after_flush_data", data, 9);
        check("after_flush_rd", rdo, 12);
        check("after_flush_trigs", trigs, 1);
        check("after_flush_resp_count", resp_count - base_resp, 1);

        // ---- asynchronous reset mid-RUN ----
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd7;
        bus.req_rd    = 5'd5;
        repeat (3) @(negedge clk);
        check("rst_run_trigger", div_trigger, 1);
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b01, 32'd9, 32'd3, 5'd13, lat, data, rdo, trigs, st_first, st_resp, uns);
        check("after_rst_data", data, 3);
        check("after_rst_rd", rdo, 13);
        check("after_rst_lat", lat, FULL_LAT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
